// File: rtl/regfile_sweep.sv
// Parametrised 2-read/1-write register file with a multi-cycle clear sweep and write-to-read bypass.
// Define REGFILE_XZR_EN to make entry DEPTH-1 a hardwired zero register.
module regfile_sweep #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] wrAddr,
  input  logic [WIDTH-1:0]     wrData,
  input  logic [ADDR_BITS-1:0] rdAddrA,
  input  logic [ADDR_BITS-1:0] rdAddrB,
  output logic [WIDTH-1:0]     rdDataA,
  output logic [WIDTH-1:0]     rdDataB,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_addr;
  logic [WIDTH-1:0]       mem_wdata;
  logic                   wr_accept;
  logic [WIDTH-1:0]       rd_a, rd_b;

`ifdef REGFILE_XZR_EN
  assign wr_accept = write && (wrAddr != LAST);
`else
  assign wr_accept = write;
`endif

  // A clear on the same idle edge as a write still lets the write land; the sweep zeroes it later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_addr  = wrAddr;
    mem_wdata = wrData;
    case (state_q)
      IDLE: begin
        mem_we = wr_accept;
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Priority: busy forces zero, then the zero register, then bypass, then storage.
  always_comb begin
    rd_a = mem_q[rdAddrA];
    rd_b = mem_q[rdAddrB];
    if (write && (wrAddr == rdAddrA)) rd_a = wrData;
    if (write && (wrAddr == rdAddrB)) rd_b = wrData;
`ifdef REGFILE_XZR_EN
    if (rdAddrA == LAST) rd_a = '0;
    if (rdAddrB == LAST) rd_b = '0;
`endif
    if (busy_q) begin
      rd_a = '0;
      rd_b = '0;
    end
  end

  assign rdDataA = rd_a;
  assign rdDataB = rd_b;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed self-checking bench for regfile_sweep (default 64x32 configuration).
module tb_regfile_sweep;

  logic        clk = 1'b0;
  logic        reset, clear, write;
  logic [4:0]  wrAddr, rdAddrA, rdAddrB;
  logic [63:0] wrData, rdDataA, rdDataB;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int n;
  logic [63:0] exp31;

  regfile_sweep dut (
    .clk(clk), .reset(reset), .clear(clear), .write(write),
    .wrAddr(wrAddr), .wrData(wrData), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdDataA(rdDataA), .rdDataB(rdDataB), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so inputs change away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0;
    wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0;

    // Reset and full sweep
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd1);
    checkOutput("reset_rd_zero", rdDataA, 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("sweep_len", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) begin
      rdAddrA = 5'(i);
      rdAddrB = 5'(31 - i);
      #1;
      checkOutput("swept_a", rdDataA, 64'd0);
      checkOutput("swept_b", rdDataB, 64'd0);
    end

    // Write and read back
    write = 1'b1; wrAddr = 5'd8; wrData = 64'hAAAAAAAAAAAAAAAA;
    applyStimulus();
    write = 1'b0; rdAddrA = 5'd8;
    #1;
    checkOutput("rd8", rdDataA, 64'hAAAAAAAAAAAAAAAA);
    write = 1'b1; wrAddr = 5'd15; wrData = 64'hCCCCCCCCCCCCCCCC;
    applyStimulus();
    write = 1'b0; rdAddrB = 5'd15;
    #1;
    checkOutput("rd15_b", rdDataB, 64'hCCCCCCCCCCCCCCCC);
    checkOutput("rd8_a_kept", rdDataA, 64'hAAAAAAAAAAAAAAAA);

    // Same-cycle bypass on both ports
    write = 1'b1; wrAddr = 5'd3; wrData = 64'h123456789ABCDEF0;
    rdAddrA = 5'd3; rdAddrB = 5'd3;
    #1;
    checkOutput("bypass_a", rdDataA, 64'h123456789ABCDEF0);
    checkOutput("bypass_b", rdDataB, 64'h123456789ABCDEF0);
    applyStimulus();
    write = 1'b0;
    #1;
    checkOutput("stored3", rdDataA, 64'h123456789ABCDEF0);

    // Write attempted during a clear sweep is dropped
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    #1;
    checkOutput("clear_busy", 64'(busy), 64'd1);
    applyStimulus();
    write = 1'b1; wrAddr = 5'd5; wrData = 64'hFFFF; rdAddrA = 5'd5;
    #1;
    checkOutput("busy_rd_zero", rdDataA, 64'd0);
    applyStimulus();
    write = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("clear_sweep_rest", 64'(n), 64'd30);
    #1;
    checkOutput("rd5_dropped", rdDataA, 64'd0);
    rdAddrB = 5'd8;
    #1;
    checkOutput("rd8_cleared", rdDataB, 64'd0);

    // Reset in the middle of a sweep restarts it
    write = 1'b1; wrAddr = 5'd20; wrData = 64'hF0F0F0F0F0F0F0F0;
    applyStimulus();
    write = 1'b0; rdAddrA = 5'd20;
    #1;
    checkOutput("rd20", rdDataA, 64'hF0F0F0F0F0F0F0F0);
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("midreset_len", 64'(n), 64'd32);
    #1;
    checkOutput("rd20_cleared", rdDataA, 64'd0);

    // Top entry: zero register when enabled, ordinary otherwise
`ifdef REGFILE_XZR_EN
    exp31 = 64'd0;
`else
    exp31 = 64'hFFFAFFFFFFFFFFFF;
`endif
    write = 1'b1; wrAddr = 5'd31; wrData = 64'hFFFAFFFFFFFFFFFF; rdAddrA = 5'd31;
    #1;
    checkOutput("x31_same_cycle", rdDataA, exp31);
    applyStimulus();
    write = 1'b0; rdAddrB = 5'd31;
    #1;
    checkOutput("x31_after_a", rdDataA, exp31);
    checkOutput("x31_after_b", rdDataB, exp31);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sweep.md
Name: regfile_sweep

Overview:
- Parametrised 2-read/1-write register file; next generation of the fixed 32x64 CPU register file.
- Width and depth are generics.
- Adds a synchronous reset that triggers a multi-cycle clear sweep, a software clear request, a busy flag, and write-to-read bypass.
- Sits in the decode stage: read ports feed the operand latches; the write port is driven by writeback.

Parameters:
- WIDTH, 64, data bits per register.
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries (32 by default).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; starts the clear sweep.
- clear  in  1  request a clear sweep while idle.
- write  in  1  write enable.
- wrAddr  in  ADDR_BITS  write address.
- wrData  in  WIDTH  write data.
- rdAddrA  in  ADDR_BITS  read address, port A.
- rdAddrB  in  ADDR_BITS  read address, port B.
- rdDataA  out  WIDTH  read data, port A (combinational).
- rdDataB  out  WIDTH  read data, port B (combinational).
- busy  out  1  high while a clear sweep is in progress (registered).

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Two states, IDLE and CLEAR, plus a sweep counter cnt (ADDR_BITS wide).

Reset and clear sweep:
- Any edge with reset=1: state<=CLEAR, cnt<=0. Memory is untouched on that edge. busy=1 from the following cycle.
- Edge in CLEAR with reset=0: mem[cnt]<=0 and cnt<=cnt+1.
  - If cnt==DEPTH-1: state<=IDLE and cnt wraps to 0.
  - busy therefore stays high for exactly DEPTH edges after reset deasserts.
- Edge in IDLE with clear=1: state<=CLEAR, cnt<=0. The sweep then runs DEPTH edges as above.
- clear is ignored while in CLEAR.
- If clear=1 and write=1 arrive on the same idle edge, the write is performed and the sweep still starts, so that entry is zeroed later.
- reset asserted mid-sweep restarts the sweep from cnt=0.

Writes:
- On an edge in IDLE with write=1: mem[wrAddr]<=wrData.
- write is ignored (dropped, not queued) while busy=1 or reset=1.

Reads:
- Reads are asynchronous.
- rdDataX = 0 while busy=1.
- Otherwise, if write=1 and wrAddr==rdAddrX, rdDataX = wrData (same-cycle bypass).
- Otherwise rdDataX = mem[rdAddrX].
- Ports A and B are independent; both may address the same entry.
- X or out-of-range addresses are never required to be handled (full decode).

Power-up and outputs:
- Before the first reset, memory contents are undefined.
- After any completed sweep, all entries read 0.
- busy reset value: 1 in the cycle after a reset edge.
- rdData outputs have no registered reset value; they follow the read rule above.

Optional Feature:
- Macro: REGFILE_XZR_EN.
- Defined: entry DEPTH-1 (X31 by default) is a hardwired zero register.
  - Reads of it always return 0, bypass included.
  - Writes to it are discarded.
  - The sweep still steps through it with no effect.
- Undefined: entry DEPTH-1 is an ordinary register.

Test Plan:
- Reset and sweep: reset=1 for 1 edge, then 0 -> busy=1 for exactly 32 edges then 0; all 32 entries read 0x0.
- Write and read back:
  - write=1, wrAddr=8, wrData=0xAAAAAAAAAAAAAAAA; one edge; write=0; rdAddrA=8 -> 0xAAAAAAAAAAAAAAAA.
  - wrAddr=15, wrData=0xCCCCCCCCCCCCCCCC; rdAddrB=15 -> 0xCCCCCCCCCCCCCCCC, with A unaffected.
- Bypass: write=1, wrAddr=3, wrData=0x123456789ABCDEF0, rdAddrA=rdAddrB=3 before the edge -> both read 0x123456789ABCDEF0 combinationally.
- Write during busy: pulse clear, then write=1, wrAddr=5, wrData=0xFFFF at sweep cycle 2 -> rdData=0 while busy; entry 5 reads 0 after busy falls.
- Reset mid-sweep: reset at sweep cycle 10 -> busy stays high 32 more edges after reset deasserts; entry 20 (written 0xF0F0F0F0F0F0F0F0 beforehand) reads 0.
- X31 with REGFILE_XZR_EN: write 0xFFFAFFFFFFFFFFFF to 31 -> reads 0 (same cycle and after). Without the macro -> reads 0xFFFAFFFFFFFFFFFF.
